syndrome_collector: RTL and testbench



---
 rtl/rs544_decoder_pkg.sv | 13 +
 rtl/syndrome_collector_if.sv | 11 +
 rtl/synd_zero_detect.sv | 9 +
 rtl/syndrome_collector.sv | 103 ++++++++++
 tb/tb_syndrome_collector.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/rs544_decoder_pkg.sv
// rs544_decoder_pkg: shared RS(544,522) decoder constants, syndrome types and buffer state encoding
package rs544_decoder_pkg;
  localparam int RS_J = 22;
  localparam int RS_SW = 10;
  localparam int RS_TAG_W = 4;
  typedef logic [0:RS_J-1][RS_SW-1:0] synd_vec_t;
  typedef struct packed {
    synd_vec_t s;
    logic [RS_TAG_W-1:0] tag;
    logic err_free;
  } synd_entry_t;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} buf_state_t;
endpackage

// File: rtl/syndrome_collector_if.sv
// syndrome_collector_if: valid/ready hand-off of one syndrome set to the key-equation solver
interface syndrome_collector_if;
  import rs544_decoder_pkg::*;
  logic valid;
  logic ready;
  synd_vec_t synd;
  logic [RS_TAG_W-1:0] tag;
  logic err_free;
  modport master(output valid, synd, tag, err_free, input ready);
  modport slave(input valid, synd, tag, err_free, output ready);
endinterface

// File: rtl/synd_zero_detect.sv
// synd_zero_detect: flags a syndrome vector whose bits are all zero (error-free codeword)
module synd_zero_detect
  import rs544_decoder_pkg::*;
(
  input  synd_vec_t s,
  output logic      zero
);
  assign zero = ~|s;
endmodule

// File: rtl/syndrome_collector.sv
// syndrome_collector: captures, tags and ping-pong buffers RS(544,522) syndrome sets for the solver.
// Optional statistics counters are built when SYND_COLLECTOR_STATS_EN is defined.
module syndrome_collector
  import rs544_decoder_pkg::*;
#(
  parameter int J = RS_J,
  parameter int SW = RS_SW,
  parameter int DEPTH = 2,
  parameter int TAG_W = RS_TAG_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  s_valid_i,
  input  logic [SW-1:0]         s_i [0:J-1],
  syndrome_collector_if.master  synd,
  output logic                  overflow_o,
  output logic [15:0]           drop_cnt_o,
  output logic [31:0]           cw_total_o,
  output logic [31:0]           cw_err_o
);
  buf_state_t state, state_nxt;
  synd_entry_t mem [DEPTH];
  synd_vec_t s_vec;
  logic s_zero;
  logic wp, rp;
  logic [TAG_W-1:0] tag_cnt;
  logic pop, push, drop, full;

  assign full = (state == TWO);
  assign pop = synd.valid && synd.ready;
  assign push = s_valid_i && (!full || pop);
  assign drop = s_valid_i && full && !pop;

  // repack the lane array into the shared syndrome vector type
  always_comb begin
    s_vec = '0;
    for (int k = 0; k < J; k++) s_vec[k] = s_i[k];
  end

  synd_zero_detect u_zero (
    .s    (s_vec),
    .zero (s_zero)
  );

  // occupancy state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= EMPTY;
    else state <= state_nxt;
  end

  // occupancy transitions; a push into a full buffer only happens alongside a pop
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY:   state_nxt = push ? ONE : EMPTY;
      ONE:     state_nxt = (push && !pop) ? TWO : (pop && !push) ? EMPTY : ONE;
      TWO:     state_nxt = (pop && !push) ? ONE : TWO;
      default: state_nxt = EMPTY;
    endcase
  end

  // entry storage, pointers, tag counter and drop bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      tag_cnt <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      if (push) begin
        mem[wp] <= {s_vec, tag_cnt, s_zero};
        wp <= ~wp;
        tag_cnt <= tag_cnt + 1'b1;
      end
      if (pop) rp <= ~rp;
      overflow_o <= drop;
      if (drop && !(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

  assign synd.valid = (state != EMPTY);
  assign synd.synd = mem[rp].s;
  assign synd.tag = mem[rp].tag;
  assign synd.err_free = mem[rp].err_free;

`ifdef SYND_COLLECTOR_STATS_EN
  // saturating counts of accepted sets and of accepted sets carrying errors
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cw_total_o <= '0;
      cw_err_o <= '0;
    end else begin
      if (push && !(&cw_total_o)) cw_total_o <= cw_total_o + 32'd1;
      if (push && !s_zero && !(&cw_err_o)) cw_err_o <= cw_err_o + 32'd1;
    end
  end
`else
  assign cw_total_o = '0;
  assign cw_err_o = '0;
`endif
endmodule

// File: tb/tb_syndrome_collector.sv
// tb_syndrome_collector: scoreboard bench for syndrome_collector against a queue-based reference model
module tb_syndrome_collector;
  import rs544_decoder_pkg::*;

  typedef struct {
    synd_vec_t s;
    logic [RS_TAG_W-1:0] tag;
    bit ef;
    int cyc;
  } exp_t;

  logic clk, rst_ni, s_valid;
  logic [RS_SW-1:0] s_arr [0:RS_J-1];
  logic overflow;
  logic [15:0] drop_cnt;
  logic [31:0] cw_total, cw_err;
  syndrome_collector_if sif();

  syndrome_collector dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .s_valid_i  (s_valid),
    .s_i        (s_arr),
    .synd       (sif),
    .overflow_o (overflow),
    .drop_cnt_o (drop_cnt),
    .cw_total_o (cw_total),
    .cw_err_o   (cw_err)
  );

  exp_t exp_q[$];
  bit drop_edge[int];
  bit push_err[int];
  logic [RS_TAG_W-1:0] tag;
  int cycle = 0;
  int tests = 0;
  int fails = 0;
  int mdrops = 0;
  int mtotal = 0;
  int merr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  function automatic void chk(string n, logic [RS_J*RS_SW-1:0] a, logic [RS_J*RS_SW-1:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h required %0h", n, cycle, a, e);
    end
  endfunction

  function automatic synd_vec_t rnd_synd();
    synd_vec_t v = '0;
    int m = $urandom_range(3);
    if (m == 1) v[$urandom_range(RS_J - 1)] = 10'($urandom_range(1023, 1));
    else if (m >= 2) for (int k = 0; k < RS_J; k++) v[k] = 10'($urandom);
    return v;
  endfunction

  // one cycle of stimulus; the model decides accept/drop from its own occupancy
  task automatic step(input bit v, input synd_vec_t s, input bit r);
    exp_t e;
    bit pop, push;
    @(posedge clk);
    #1;
    s_valid = v;
    for (int k = 0; k < RS_J; k++) s_arr[k] = s[k];
    sif.ready = r;
    pop = (exp_q.size() > 0) && r;
    push = v && (exp_q.size() < 2 || pop);
    if (push) begin
      e.s = s;
      e.tag = tag;
      e.ef = (s == '0);
      e.cyc = cycle;
      exp_q.push_back(e);
      push_err[cycle + 1] = !e.ef;
      tag = tag + 1'b1;
    end else if (v) begin
      drop_edge[cycle + 1] = 1'b1;
    end
  endtask

  // monitor: compares the DUT head and side outputs against the model each cycle
  always @(negedge clk) begin
    if (!rst_ni) begin
      mdrops = 0;
      mtotal = 0;
      merr = 0;
    end else begin
      bit ev;
      if (drop_edge.exists(cycle) && mdrops < 16'hFFFF) mdrops++;
      chk("overflow", overflow, drop_edge.exists(cycle));
      chk("drop_cnt", drop_cnt, mdrops);
      if (push_err.exists(cycle)) begin
        mtotal++;
        if (push_err[cycle]) merr++;
      end
`ifdef SYND_COLLECTOR_STATS_EN
      chk("cw_total", cw_total, mtotal);
      chk("cw_err", cw_err, merr);
`else
      chk("cw_total", cw_total, 0);
      chk("cw_err", cw_err, 0);
`endif
      ev = (exp_q.size() > 0) && (exp_q[0].cyc < cycle);
      chk("synd_valid", sif.valid, ev);
      if (ev && sif.valid) begin
        chk("synd", sif.synd, exp_q[0].s);
        chk("tag", sif.tag, exp_q[0].tag);
        chk("err_free", sif.err_free, exp_q[0].ef);
        if (sif.ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_all_zero(string n);
    chk({n, "_valid"}, sif.valid, 0);
    chk({n, "_synd"}, sif.synd, 0);
    chk({n, "_tag"}, sif.tag, 0);
    chk({n, "_err_free"}, sif.err_free, 0);
    chk({n, "_overflow"}, overflow, 0);
    chk({n, "_drop_cnt"}, drop_cnt, 0);
    chk({n, "_cw_total"}, cw_total, 0);
    chk({n, "_cw_err"}, cw_err, 0);
  endtask

  initial begin
    synd_vec_t z, a;
    z = '0;
    tag = '0;
    rst_ni = 1'b0;
    s_valid = 1'b0;
    sif.ready = 1'b0;
    for (int k = 0; k < RS_J; k++) s_arr[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_ni = 1'b1;
    repeat (8) step(0, z, 1);
    step(1, z, 1);
    repeat (3) step(0, z, 1);
    a = '0;
    a[0] = 10'h001;
    step(1, a, 1);
    a = '0;
    a[21] = 10'h3FF;
    step(1, a, 1);
    repeat (3) step(0, z, 1);
    step(1, rnd_synd(), 0);
    step(0, z, 0);
    step(1, rnd_synd(), 0);
    step(0, z, 0);
    step(1, rnd_synd(), 0);
    repeat (3) step(0, z, 0);
    repeat (3) step(0, z, 1);
    step(1, rnd_synd(), 1);
    repeat (2) step(0, z, 1);
    step(1, rnd_synd(), 0);
    step(1, rnd_synd(), 0);
    step(1, rnd_synd(), 1);
    step(0, z, 0);
    repeat (4) step(0, z, 1);
    repeat (17) step(1, rnd_synd(), 1);
    repeat (3) step(0, z, 1);
    step(1, rnd_synd(), 0);
    step(1, rnd_synd(), 0);
    step(0, z, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    s_valid = 1'b0;
    exp_q.delete();
    drop_edge.delete();
    push_err.delete();
    tag = '0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    step(1, rnd_synd(), 1);
    repeat (3) step(0, z, 1);
    for (int i = 0; i < 2000; i++) step($urandom_range(1), rnd_synd(), $urandom_range(9) < 6);
    repeat (10) step(0, z, 1);
    @(negedge clk);
    chk("drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
